// File: rtl/config_loader.sv
// config_loader: replays a header + addr/data word stream onto the fabric
// config bus, one write strobe per pair followed by a programmable settle gap.
// fabric_en is raised only after a complete, error-free load.
module config_loader #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned MAX_WRITES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        config_we,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        fabric_en,
  output logic [15:0] write_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_ADDR  = 3'd2,
    S_DATA  = 3'd3,
    S_ISSUE = 3'd4,
    S_GAP   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam bit          HAS_GAP  = (GAP_CYCLES > 0);
  localparam int unsigned GAP_INIT = HAS_GAP ? (GAP_CYCLES - 1) : 0;

  state_t      state_r;
  state_t      state_s;
  logic [15:0] hdr_n_r;
  logic [15:0] count_r;
  logic [15:0] gap_cnt_r;
  logic [31:0] addr_r;
  logic [31:0] data_r;
  logic        we_r;
  logic        busy_r;
  logic        done_r;
  logic        err_r;

  logic        ready_s;
  logic        accept_s;
  logic        start_s;
  logic        hdr_err_s;
  logic        last_s;
  logic        busy_s;
  logic [15:0] n_in_s;

  // Stream words are only taken while waiting on header, address or data.
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      S_HDR, S_ADDR, S_DATA: ready_s = 1'b1;
      default:               ready_s = 1'b0;
    endcase
  end

  assign accept_s = in_valid & ready_s;
  assign n_in_s   = in_data[15:0];
  assign last_s   = (count_r == hdr_n_r);

  // Next-state decode; start is honoured only from an idle or finished load.
  always_comb begin
    state_s   = state_r;
    start_s   = 1'b0;
    hdr_err_s = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_s = S_HDR;
          start_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      S_HDR: begin
        if (accept_s) begin
          if (n_in_s == 16'd0) begin
            state_s = S_DONE;
          end else if ({16'd0, n_in_s} > 32'(MAX_WRITES)) begin
            state_s   = S_IDLE;
            hdr_err_s = 1'b1;
          end else begin
            state_s = S_ADDR;
          end
        end else begin
          state_s = S_HDR;
        end
      end
      S_ADDR: begin
        if (accept_s) state_s = S_DATA;
        else          state_s = S_ADDR;
      end
      S_DATA: begin
        if (accept_s) state_s = S_ISSUE;
        else          state_s = S_DATA;
      end
      S_ISSUE: begin
        if (HAS_GAP)     state_s = S_GAP;
        else if (last_s) state_s = S_DONE;
        else             state_s = S_ADDR;
      end
      S_GAP: begin
        if (gap_cnt_r == 16'd0) begin
          if (last_s) state_s = S_DONE;
          else        state_s = S_ADDR;
        end else begin
          state_s = S_GAP;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Busy covers every state between header wait and the end of the last gap.
  always_comb begin
    busy_s = 1'b0;
    case (state_s)
      S_HDR, S_ADDR, S_DATA, S_ISSUE, S_GAP: busy_s = 1'b1;
      default:                               busy_s = 1'b0;
    endcase
  end

  // State, datapath and status registers; status outputs follow the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      hdr_n_r   <= 16'd0;
      count_r   <= 16'd0;
      gap_cnt_r <= 16'd0;
      addr_r    <= 32'd0;
      data_r    <= 32'd0;
      we_r      <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      we_r    <= (state_s == S_ISSUE);
      busy_r  <= busy_s;
      done_r  <= (state_s == S_DONE);

      if (start_s)        err_r <= 1'b0;
      else if (hdr_err_s) err_r <= 1'b1;
      else                err_r <= err_r;

      if (start_s)                            hdr_n_r <= 16'd0;
      else if ((state_r == S_HDR) && accept_s) hdr_n_r <= n_in_s;
      else                                    hdr_n_r <= hdr_n_r;

      // Counted on the data accept so the strobe cycle already shows the new total.
      if (start_s)                             count_r <= 16'd0;
      else if ((state_r == S_DATA) && accept_s) count_r <= count_r + 16'd1;
      else                                     count_r <= count_r;

      if ((state_r == S_ADDR) && accept_s) addr_r <= in_data;
      else                                 addr_r <= addr_r;

      if ((state_r == S_DATA) && accept_s) data_r <= in_data;
      else                                 data_r <= data_r;

      if ((state_s == S_GAP) && (state_r != S_GAP)) gap_cnt_r <= 16'(GAP_INIT);
      else if ((state_r == S_GAP) && (gap_cnt_r != 16'd0)) gap_cnt_r <= gap_cnt_r - 16'd1;
      else gap_cnt_r <= gap_cnt_r;
    end
  end

  assign in_ready    = ready_s;
  assign config_addr = addr_r;
  assign config_data = data_r;
  assign config_we   = we_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;
  assign fabric_en   = done_r;
  assign write_count = count_r;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: a cycle table for the back-to-back case
// (no gap) and hand-written sequences for gap, stall, error and reset cases.
module tb_config_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [31:0] in_data;

  logic        rdy0, we0, busy0, done0, err0, fen0;
  logic [31:0] addr0, data0;
  logic [15:0] cnt0;
  logic        rdy2, we2, busy2, done2, err2, fen2;
  logic [31:0] addr2, data2;
  logic [15:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  config_loader #(.GAP_CYCLES(0), .MAX_WRITES(1024)) u_gap0 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .config_addr(addr0), .config_data(data0), .config_we(we0),
    .busy(busy0), .done(done0), .err(err0), .fabric_en(fen0), .write_count(cnt0)
  );

  config_loader #(.GAP_CYCLES(2), .MAX_WRITES(1024)) u_gap2 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy2),
    .in_data(in_data), .config_addr(addr2), .config_data(data2), .config_we(we2),
    .busy(busy2), .done(done2), .err(err2), .fabric_en(fen2), .write_count(cnt2)
  );

  typedef struct {
    logic        rst;
    logic        st;
    logic        vld;
    logic [31:0] din;
    logic        we;
    logic [31:0] addr;
    logic [31:0] cdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        fen;
    logic        rdy;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [10];

  // Apply inputs at a falling edge, let one rising edge pass, return at the next falling edge.
  task automatic step(input logic r, input logic s, input logic v, input logic [31:0] d);
    reset    = r;
    start    = s;
    in_valid = v;
    in_data  = d;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Snapshot of the GAP_CYCLES=2 instance: {we,busy,done,err,fen,rdy}.
  function automatic logic [31:0] flags2();
    return {26'd0, we2, busy2, done2, err2, fen2, rdy2};
  endfunction

  initial begin
    logic [85:0] act_v, exp_v;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 32'd0;
    @(negedge clk);

    // ---- Table: GAP=0, N=2, pairs (0x10,0xA),(0x20,0xB), in_valid held high ----
    //             rst   st    vld   din            we    addr      cdata    busy  done  err   fen   rdy   cnt
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h2,        1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h10,       1'b0, 32'h10, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'hA,        1'b1, 32'h10, 32'hA,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h20,       1'b0, 32'h10, 32'hA,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h20,       1'b0, 32'h20, 32'hA,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 32'hB,        1'b1, 32'h20, 32'hB,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 32'hDEAD,     1'b0, 32'h20, 32'hB,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2};
    vecs[9] = '{1'b1, 1'b0, 1'b1, 32'hBEEF,     1'b0, 32'h20, 32'hB,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2};

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].rst, vecs[i].st, vecs[i].vld, vecs[i].din);
      act_v = {we0, addr0, data0, busy0, done0, err0, fen0, rdy0, cnt0};
      exp_v = {vecs[i].we, vecs[i].addr, vecs[i].cdata, vecs[i].busy, vecs[i].done,
               vecs[i].err, vecs[i].fen, vecs[i].rdy, vecs[i].cnt};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL gap0_row%0d actual=%h expected=%h", i, act_v, exp_v);
      end
    end

    // ---- GAP=2, N=1, in_valid dropped 3 cycles between addr and data ----
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h1);
    step(1'b1, 1'b0, 1'b1, 32'h30);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h99);
      chk("stall_wait", flags2(), 32'b010001);
    end
    step(1'b1, 1'b0, 1'b1, 32'h55);
    chk("stall_issue_flags", flags2(), 32'b110000);
    chk("stall_issue_addr", addr2, 32'h30);
    chk("stall_issue_data", data2, 32'h55);
    chk("stall_issue_cnt", {16'd0, cnt2}, 32'd1);
    step(1'b1, 1'b0, 1'b1, 32'h77);
    chk("gap_cycle1", flags2(), 32'b010000);
    step(1'b1, 1'b0, 1'b1, 32'h77);
    chk("gap_cycle2", flags2(), 32'b010000);
    step(1'b1, 1'b0, 1'b1, 32'h77);
    chk("gap_done_flags", flags2(), 32'b001010);
    chk("gap_done_cnt", {16'd0, cnt2}, 32'd1);
    chk("gap_done_addr_hold", addr2, 32'h30);

    // ---- Header N=0 (upper header bits set, ignored) ----
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("n0_hdr_flags", flags2(), 32'b010001);
    chk("n0_hdr_cnt_clr", {16'd0, cnt2}, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_0000);
    chk("n0_done_flags", flags2(), 32'b001010);
    chk("n0_done_cnt", {16'd0, cnt2}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("n0_done_hold", flags2(), 32'b001010);

    // ---- Header N=MAX_WRITES+1 -> error, then next start clears it ----
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'hABCD_0401);
    chk("ovf_flags", flags2(), 32'b000100);
    chk("ovf_cnt", {16'd0, cnt2}, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'h5);
    chk("ovf_idle_hold", flags2(), 32'b000100);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("ovf_restart", flags2(), 32'b010001);

    // ---- Header N=MAX_WRITES is legal ----
    step(1'b1, 1'b0, 1'b1, 32'd1024);
    chk("max_hdr_ok", flags2(), 32'b010001);

    // ---- Reset after first of 3 writes, then fresh load ----
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h3);
    step(1'b1, 1'b0, 1'b1, 32'h40);
    step(1'b1, 1'b0, 1'b1, 32'h61);
    chk("rst_pre_flags", flags2(), 32'b110000);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_flags", flags2(), 32'b000000);
    chk("rst_addr", addr2, 32'h0);
    chk("rst_data", data2, 32'h0);
    chk("rst_cnt", {16'd0, cnt2}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h1);
    chk("reload_cnt0", {16'd0, cnt2}, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'h44);
    // start pulse while busy must be ignored
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("busy_start_ign", flags2(), 32'b010001);
    step(1'b1, 1'b0, 1'b1, 32'h66);
    chk("reload_issue_flags", flags2(), 32'b110000);
    chk("reload_issue_cnt", {16'd0, cnt2}, 32'd1);
    chk("reload_issue_addr", addr2, 32'h44);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("gap_start_ign", flags2(), 32'b010000);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("reload_done", flags2(), 32'b001010);
    chk("reload_done_cnt", {16'd0, cnt2}, 32'd1);
    // start in DONE reloads and drops fabric_en
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("done_restart_flags", flags2(), 32'b010001);
    chk("done_restart_cnt", {16'd0, cnt2}, 32'd0);
    chk("done_restart_addr_hold", addr2, 32'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
